// File: rtl/tx_byte_serializer.sv
// MSB-first serializer that drains the tag byte FIFO into a gap-free, fixed-rate bitstream.
// Define TX_SERIALIZER_CRC16_EN to append the inverted CRC-16 (poly 0x1021, preset 0xFFFF) to each frame.
`timescale 1ns/1ps
module tx_byte_serializer #(
  parameter int BIT_DIV = 4,
  parameter int CNT_W   = 8
) (
  input  logic             r_clk,
  input  logic             reset_n,
  input  logic             en,
  input  logic             start,
  input  logic             empty,
  input  logic [7:0]       data_in,
  output logic             read,
  output logic             bit_out,
  output logic             bit_strobe,
  output logic             tx_active,
  output logic             done,
  output logic [CNT_W-1:0] byte_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_SHIFT,
    S_CRC,
    S_DONE
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(BIT_DIV - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [7:0]       r_shreg;
  logic [7:0]       r_hold;
  logic             r_hold_valid;
  logic             r_fetch_pend;
  logic [3:0]       r_bit_cnt;
  logic [7:0]       r_div_cnt;
  logic [CNT_W-1:0] r_byte_count;

  logic w_clr;
  logic w_bit_end;
  logic w_start_ok;
  logic w_pop_next;
  logic w_have_next;
  logic w_last_data;

  // en low behaves exactly like reset: immediate abort with no done pulse.
  assign w_clr       = ~reset_n | ~en;
  assign w_bit_end   = (r_div_cnt == DIV_LAST);
  assign w_start_ok  = (r_state == S_IDLE) && start && !empty;
  assign w_pop_next  = (r_state == S_SHIFT) && (r_bit_cnt == 4'd7) && (r_div_cnt == 8'd0) && !empty;
  // With BIT_DIV=2 the prefetched byte arrives on the final cycle of bit 7, so bypass the hold register.
  assign w_have_next = r_hold_valid | r_fetch_pend;
  assign w_last_data = (r_state == S_SHIFT) && (r_bit_cnt == 4'd7) && w_bit_end;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge r_clk) begin
    if (w_clr) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  // NOTE: defaults are assigned first so no path through the case leaves a variable unassigned (no latch).
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_next_state = S_FETCH;
      S_FETCH: w_next_state = S_WAIT;
      S_WAIT:  w_next_state = S_SHIFT;
      S_SHIFT: begin
        if (w_last_data && !w_have_next) begin
`ifdef TX_SERIALIZER_CRC16_EN
          w_next_state = S_CRC;
`else
          w_next_state = S_DONE;
`endif
        end
      end
`ifdef TX_SERIALIZER_CRC16_EN
      S_CRC:   if ((r_bit_cnt == 4'd15) && w_bit_end) w_next_state = S_DONE;
`endif
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge r_clk) begin
    if (w_clr) begin
      r_shreg      <= '0;
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_fetch_pend <= 1'b0;
      r_bit_cnt    <= '0;
      r_div_cnt    <= '0;
      r_byte_count <= '0;
    end else begin
      r_fetch_pend <= w_pop_next;
      if (w_start_ok) begin
        r_byte_count <= '0;
        r_hold_valid <= 1'b0;
      end
      if (r_fetch_pend) begin
        r_hold       <= data_in;
        r_hold_valid <= 1'b1;
      end
      case (r_state)
        S_WAIT: begin
          r_shreg   <= data_in;
          r_bit_cnt <= '0;
          r_div_cnt <= '0;
        end
        S_SHIFT: begin
          r_div_cnt <= w_bit_end ? 8'd0 : r_div_cnt + 8'd1;
          if (w_bit_end) begin
            if (r_bit_cnt == 4'd7) begin
              r_bit_cnt <= '0;
              if (r_byte_count != '1) r_byte_count <= r_byte_count + CNT_W'(1);
              if (w_have_next) begin
                r_shreg      <= r_fetch_pend ? data_in : r_hold;
                r_hold_valid <= 1'b0;
              end
            end else begin
              r_shreg   <= {r_shreg[6:0], 1'b0};
              r_bit_cnt <= r_bit_cnt + 4'd1;
            end
          end
        end
        S_CRC: begin
          r_div_cnt <= w_bit_end ? 8'd0 : r_div_cnt + 8'd1;
          if (w_bit_end) r_bit_cnt <= r_bit_cnt + 4'd1;
        end
        default: ;
      endcase
    end
  end

`ifdef TX_SERIALIZER_CRC16_EN
  localparam logic [15:0] CRC_PRESET = 16'hFFFF;
  localparam logic [15:0] CRC_POLY   = 16'h1021;

  logic [15:0] r_crc;
  logic [15:0] r_crc_sh;
  logic [15:0] w_crc_next;
  logic        w_crc_fb;

  always_comb begin
    w_crc_fb   = r_crc[15] ^ r_shreg[7];
    w_crc_next = {r_crc[14:0], 1'b0} ^ (w_crc_fb ? CRC_POLY : 16'h0000);
  end

  // The complemented CRC is latched into its own shifter on the last data bit so it can go out MSB-first.
  always_ff @(posedge r_clk) begin
    if (w_clr) begin
      r_crc    <= '0;
      r_crc_sh <= '0;
    end else begin
      if (w_start_ok) r_crc <= CRC_PRESET;
      if ((r_state == S_SHIFT) && w_bit_end) begin
        r_crc <= w_crc_next;
        if ((r_bit_cnt == 4'd7) && !w_have_next) r_crc_sh <= ~w_crc_next;
      end
      if ((r_state == S_CRC) && w_bit_end) r_crc_sh <= {r_crc_sh[14:0], 1'b0};
    end
  end
`endif

  always_comb begin
    read       = (r_state == S_FETCH) | w_pop_next;
    tx_active  = (r_state == S_SHIFT) | (r_state == S_CRC);
    bit_strobe = tx_active && (r_div_cnt == 8'd0);
    done       = (r_state == S_DONE);
    byte_count = r_byte_count;
    bit_out    = 1'b0;
    if (r_state == S_SHIFT) bit_out = r_shreg[7];
`ifdef TX_SERIALIZER_CRC16_EN
    else if (r_state == S_CRC) bit_out = r_crc_sh[15];
`endif
  end

endmodule

// File: tb/tb_tx_byte_serializer.sv
// Scoreboard bench for tx_byte_serializer: stimulus queues the expected bitstream, a negedge monitor checks it.
// The CRC trailer is expected only when TX_SERIALIZER_CRC16_EN is defined for the build.
`timescale 1ns/1ps
module tb_tx_byte_serializer;

  localparam int BIT_DIV = 4;
  localparam int CNT_W   = 8;
`ifdef TX_SERIALIZER_CRC16_EN
  localparam bit CRC_ON = 1'b1;
`else
  localparam bit CRC_ON = 1'b0;
`endif

  logic             r_clk   = 1'b0;
  logic             reset_n = 1'b0;
  logic             en      = 1'b1;
  logic             start   = 1'b0;
  logic             empty   = 1'b1;
  logic [7:0]       data_in = 8'h00;
  logic             read;
  logic             bit_out;
  logic             bit_strobe;
  logic             tx_active;
  logic             done;
  logic [CNT_W-1:0] byte_count;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  byte unsigned fifo_q[$];
  bit           exp_bits[$];
  int           t0;
  int           exp_nbits;
  int           exp_reads;
  int           exp_cnt;
  bit           mon_on = 1'b0;
  int           frame_strobes;
  int           frame_reads;
  int           frames_done = 0;
  int           last_strobe_cyc;
  bit           last_exp_bit;

  tx_byte_serializer #(
    .BIT_DIV (BIT_DIV),
    .CNT_W   (CNT_W)
  ) dut (
    .r_clk      (r_clk),
    .reset_n    (reset_n),
    .en         (en),
    .start      (start),
    .empty      (empty),
    .data_in    (data_in),
    .read       (read),
    .bit_out    (bit_out),
    .bit_strobe (bit_strobe),
    .tx_active  (tx_active),
    .done       (done),
    .byte_count (byte_count)
  );

  always #5 r_clk = ~r_clk;
  always @(posedge r_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // FIFO model: data for a pop in cycle N appears during cycle N+1.
  always @(posedge r_clk) begin
    if (read === 1'b1) begin
      check("read_while_empty", (fifo_q.size() != 0), 1);
      if (fifo_q.size() != 0) data_in <= fifo_q.pop_front();
    end
  end
  always @(negedge r_clk) empty = (fifo_q.size() == 0);

  // Monitor: consumes one expected bit per bit_strobe and checks frame bookkeeping at done.
  always @(negedge r_clk) begin
    if (mon_on) begin
      if (bit_strobe === 1'b1) begin
        frame_strobes++;
        if (frame_strobes == 1) check("first_strobe_latency", cyc - t0, 3);
        else                    check("strobe_spacing", cyc - last_strobe_cyc, BIT_DIV);
        last_strobe_cyc = cyc;
        check("tx_active_on_strobe", tx_active, 1);
        if (exp_bits.size() == 0) begin
          check("unexpected_bit", frame_strobes, exp_nbits);
        end else begin
          last_exp_bit = exp_bits.pop_front();
          check("bit_out", bit_out, last_exp_bit);
        end
      end else if (tx_active === 1'b1) begin
        check("bit_hold", bit_out, last_exp_bit);
      end
      if (read === 1'b1) begin
        frame_reads++;
        if (frame_reads == 1) begin
          check("first_read_latency", cyc - t0, 1);
        end else begin
          check("prefetch_on_strobe", bit_strobe, 1);
          check("prefetch_bit7", frame_strobes % 8, 0);
        end
      end
      if (done === 1'b1) begin
        check("done_latency", cyc - t0, 3 + exp_nbits * BIT_DIV);
        check("done_tx_active", tx_active, 0);
        check("done_bit_out", bit_out, 0);
        check("done_byte_count", byte_count, exp_cnt);
        check("bits_sent", frame_strobes, exp_nbits);
        check("read_pulses", frame_reads, exp_reads);
        frames_done++;
      end
    end
  end

  task automatic send_frame(input string tag, input byte unsigned data[$]);
    int          nbits;
    int          bound;
    int          target;
    logic [15:0] crc;
    bit          db;
    bit          fb;
    byte unsigned d;
    crc = 16'hFFFF;
    exp_bits.delete();
    foreach (data[i]) begin
      d = data[i];
      fifo_q.push_back(d);
      for (int b = 7; b >= 0; b--) begin
        db = d[b];
        exp_bits.push_back(db);
        fb  = crc[15] ^ db;
        crc = {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
    end
    if (CRC_ON) begin
      crc = ~crc;
      for (int b = 15; b >= 0; b--) exp_bits.push_back(crc[b]);
    end
    nbits     = data.size() * 8 + (CRC_ON ? 16 : 0);
    exp_nbits = nbits;
    exp_reads = data.size();
    exp_cnt   = (data.size() > (2**CNT_W - 1)) ? (2**CNT_W - 1) : data.size();
    frame_strobes = 0;
    frame_reads   = 0;
    @(negedge r_clk);
    @(negedge r_clk);
    target = frames_done + 1;
    start  = 1'b1;
    t0     = cyc;
    mon_on = 1'b1;
    @(negedge r_clk);
    start = 1'b0;
    bound = nbits * BIT_DIV + 20;
    while ((frames_done != target) && (bound > 0)) begin
      @(negedge r_clk);
      bound--;
    end
    check({"frame_done_", tag}, frames_done, target);
    @(negedge r_clk);
    check({"count_hold_", tag}, byte_count, exp_cnt);
    check({"idle_after_", tag}, tx_active, 0);
  endtask

  task automatic abort_run(input string tag, input bit use_en);
    int bad;
    mon_on = 1'b0;
    fifo_q.push_back(8'h3C);
    fifo_q.push_back(8'hC3);
    @(negedge r_clk);
    @(negedge r_clk);
    start = 1'b1;
    t0    = cyc;
    @(negedge r_clk);
    start = 1'b0;
    repeat (15) @(negedge r_clk);
    check({"abort_pre_active_", tag}, tx_active, 1);
    if (use_en) en = 1'b0;
    else        reset_n = 1'b0;
    @(negedge r_clk);
    check({"abort_outputs_", tag}, {read, bit_out, bit_strobe, tx_active, done}, 0);
    check({"abort_count_", tag}, byte_count, 0);
    en      = 1'b1;
    reset_n = 1'b1;
    bad = 0;
    repeat (40) begin
      @(negedge r_clk);
      if ((read !== 1'b0) || (done !== 1'b0) || (tx_active !== 1'b0)) bad++;
    end
    check({"abort_quiet_", tag}, bad, 0);
    check({"abort_fifo_left_", tag}, fifo_q.size(), 1);
    fifo_q.delete();
    @(negedge r_clk);
  endtask

  initial begin
    int bad;
    byte unsigned q[$];
    int n;

    reset_n = 1'b0;
    start   = 1'b1;
    fifo_q.push_back(8'h5A);
    bad = 0;
    repeat (6) begin
      @(negedge r_clk);
      if (({read, bit_out, bit_strobe, tx_active, done} !== 5'b0) || (byte_count !== '0)) bad++;
    end
    check("reset_quiet", bad, 0);
    check("reset_byte_count", byte_count, 0);
    start = 1'b0;
    fifo_q.delete();
    @(negedge r_clk);
    reset_n = 1'b1;
    @(negedge r_clk);

    q.delete(); q.push_back(8'hA5);
    send_frame("a5", q);
    q.delete(); q.push_back(8'h00); q.push_back(8'hFF);
    send_frame("00ff", q);

    // An empty FIFO must leave the block idle and keep the previous count.
    start = 1'b1;
    @(negedge r_clk);
    start = 1'b0;
    bad = 0;
    repeat (50) begin
      @(negedge r_clk);
      if ((read !== 1'b0) || (tx_active !== 1'b0) || (done !== 1'b0) || (bit_strobe !== 1'b0)) bad++;
    end
    check("empty_start_quiet", bad, 0);
    check("empty_start_count_held", byte_count, 2);

    abort_run("rst", 1'b0);
    abort_run("en", 1'b1);

    for (int f = 0; f < 6; f++) begin
      q.delete();
      n = $urandom_range(4, 1);
      for (int k = 0; k < n; k++) q.push_back(8'($urandom()));
      send_frame("rand", q);
    end

    q.delete();
    for (int k = 0; k < 257; k++) q.push_back(8'($urandom()));
    send_frame("saturate", q);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
